// File: rtl/byte_serializer_if.sv
// Upstream buffer handshake and serial output bundle for byte_serializer.
// master = upstream/driver side, slave = the serializer.
interface byte_serializer_if;
  logic [7:0] DATA_IN;
  logic       Valid;
  logic       EMPTY;
  logic       READ;
  logic       DATA_OUT;
  logic       Valid_out;
  logic       BUSY;
  logic       ERR;

  modport master (
    output DATA_IN, Valid, EMPTY,
    input  READ, DATA_OUT, Valid_out, BUSY, ERR
  );

  modport slave (
    input  DATA_IN, Valid, EMPTY,
    output READ, DATA_OUT, Valid_out, BUSY, ERR
  );
endinterface

// File: rtl/byte_serializer.sv
// Pops bytes from an upstream buffer and shifts them out one bit per cycle.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module byte_serializer #(
  parameter int WAIT_MAX  = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  byte_serializer_if.slave bus,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
`ifdef SERIALIZER_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_SHIFT  = 3'd3
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT_MAX - 1);

  state_t     r_state;
  state_t     w_state_d;
  logic [3:0] r_wait_cnt, w_wait_cnt_d;
  logic [2:0] r_bit_cnt, w_bit_cnt_d;
  logic [7:0] r_shift, w_shift_d;
  logic       r_read, w_read_d;
  logic       r_data_out, w_data_out_d;
  logic       r_valid_out, w_valid_out_d;
  logic       r_busy;
  logic       r_err, w_err_d;
`ifdef SERIALIZER_PARITY_EN
  logic       r_par, w_par_d;
`endif

  logic w_load;
  logic w_timeout;

  assign w_load    = ((r_state == S_REQ) || (r_state == S_WAIT)) && bus.Valid;
  assign w_timeout = (r_wait_cnt == LP_WAIT_LAST);

  // State register and all registered outputs/datapath.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_read      <= 1'b0;
      r_data_out  <= 1'b0;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shift     <= w_shift_d;
      r_read      <= w_read_d;
      r_data_out  <= w_data_out_d;
      r_valid_out <= w_valid_out_d;
      r_busy      <= (w_state_d != S_IDLE);
      r_err       <= w_err_d;
`ifdef SERIALIZER_PARITY_EN
      r_par       <= w_par_d;
`endif
    end
  end

  // Next-state logic; Valid beats the timeout on the same WAIT edge.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:  if (!bus.EMPTY) w_state_d = S_REQ;
      S_REQ:   w_state_d = bus.Valid ? S_SHIFT : S_WAIT;
      S_WAIT: begin
        if (bus.Valid)      w_state_d = S_SHIFT;
        else if (w_timeout) w_state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (r_bit_cnt == 3'd7) begin
`ifdef SERIALIZER_PARITY_EN
          w_state_d = S_PARITY;
`else
          w_state_d = S_IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: w_state_d = S_IDLE;
`endif
      default: w_state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the load edge already emits bit 0.
  always_comb begin
    w_read_d      = 1'b0;
    w_data_out_d  = 1'b0;
    w_valid_out_d = 1'b0;
    w_err_d       = r_err;
    w_wait_cnt_d  = r_wait_cnt;
    w_bit_cnt_d   = r_bit_cnt;
    w_shift_d     = r_shift;
`ifdef SERIALIZER_PARITY_EN
    w_par_d       = r_par;
`endif
    if (w_load) begin
      w_shift_d     = MSB_FIRST ? {bus.DATA_IN[6:0], 1'b0} : {1'b0, bus.DATA_IN[7:1]};
      w_data_out_d  = MSB_FIRST ? bus.DATA_IN[7] : bus.DATA_IN[0];
      w_valid_out_d = 1'b1;
      w_bit_cnt_d   = '0;
      w_wait_cnt_d  = '0;
`ifdef SERIALIZER_PARITY_EN
      w_par_d       = ^bus.DATA_IN;
`endif
    end else begin
      case (r_state)
        S_IDLE: w_read_d = !bus.EMPTY;
        S_REQ:  w_wait_cnt_d = '0;
        S_WAIT: begin
          if (w_timeout) begin
            w_err_d      = 1'b1;
            w_wait_cnt_d = '0;
          end else begin
            w_wait_cnt_d = r_wait_cnt + 4'd1;
          end
        end
        S_SHIFT: begin
          if (r_bit_cnt != 3'd7) begin
            w_data_out_d  = MSB_FIRST ? r_shift[7] : r_shift[0];
            w_shift_d     = MSB_FIRST ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
            w_valid_out_d = 1'b1;
            w_bit_cnt_d   = r_bit_cnt + 3'd1;
          end else begin
            w_bit_cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
            w_data_out_d  = r_par;
            w_valid_out_d = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.READ      = r_read;
  assign bus.DATA_OUT  = r_data_out;
  assign bus.Valid_out = r_valid_out;
  assign bus.BUSY      = r_busy;
  assign bus.ERR       = r_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: MSB-first instance plus an LSB-first instance.
// Parity expectations follow SERIALIZER_PARITY_EN.
module tb_byte_serializer;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;

  logic       CLK;
  logic       RESET;
  logic [2:0] dbg_state;
  logic [2:0] dbg_state_lsb;

  int n_checks;
  int n_errors;

  byte_serializer_if bus ();
  byte_serializer_if bus2 ();

  byte_serializer #(.WAIT_MAX(4), .MSB_FIRST(1'b1)) u_dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus),
    .o_state (dbg_state)
  );

  byte_serializer #(.WAIT_MAX(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus2),
    .o_state (dbg_state_lsb)
  );

  // clock / global timeout
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full frame on the MSB-first instance, starting from IDLE.
  // delay = number of WAIT cycles before Valid (0 = Valid in REQ).
  task automatic run_frame(input string tag, input logic [7:0] d, input int delay,
                           input logic [7:0] exp_bits, input logic exp_par);
    logic [7:0] got;
    int         vo_cnt;
    got    = '0;
    vo_cnt = 0;
    bus.EMPTY   = 1'b0;
    bus.DATA_IN = d;
    bus.Valid   = 1'b0;
    tick();
    check({tag, ".read"}, {bus.READ, bus.Valid_out, bus.BUSY}, 3'b101);
    bus.Valid = (delay == 0);
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, ".wait"}, {bus.READ, bus.Valid_out, dbg_state}, {2'b00, ST_WAIT});
      bus.Valid = (i == delay - 1);
    end
    tick();
    bus.Valid   = 1'b0;
    bus.DATA_IN = ~d;
    check({tag, ".read_once"}, bus.READ, 1'b0);
    for (int k = 0; k < 8; k++) begin
      got[7-k] = bus.DATA_OUT;
      if (bus.Valid_out) vo_cnt++;
      if (k < 7) tick();
    end
    check({tag, ".bits"}, got, exp_bits);
    check({tag, ".vo_cnt"}, vo_cnt, 8);
    tick();
`ifdef SERIALIZER_PARITY_EN
    check({tag, ".parity"}, {bus.Valid_out, bus.DATA_OUT}, {1'b1, exp_par});
    tick();
`else
    if (exp_par === 1'bx) $display("note: %s parity unknown", tag);
`endif
    check({tag, ".end"}, {bus.Valid_out, bus.DATA_OUT, dbg_state}, {2'b00, ST_IDLE});
  endtask

  // Directed vectors: data, WAIT delay, expected serial (first bit = MSB), parity.
  logic [7:0] vec_d   [4] = '{8'hAA, 8'hBB, 8'hA6, 8'hA8};
  int         vec_dly [4] = '{2, 0, 0, 4};
  logic [7:0] vec_exp [4] = '{8'b1010_1010, 8'b1011_1011, 8'b1010_0110, 8'b1010_1000};
  logic       vec_par [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [7:0] lsb_d   [2] = '{8'h01, 8'hB4};
  int         lsb_dly [2] = '{0, 1};
  logic [7:0] lsb_exp [2] = '{8'b1000_0000, 8'b0010_1101};
  logic       lsb_par [2] = '{1'b1, 1'b0};

  initial begin
    logic       vo_seen;
    logic       rd_seen;
    logic [7:0] got;
    int         vo_cnt;
    n_checks = 0;
    n_errors = 0;
    RESET        = 1'b1;
    bus.DATA_IN  = 8'h00;
    bus.Valid    = 1'b0;
    bus.EMPTY    = 1'b1;
    bus2.DATA_IN = 8'h00;
    bus2.Valid   = 1'b0;
    bus2.EMPTY   = 1'b1;

    // reset held 3 edges with EMPTY=1
    rd_seen = 1'b0;
    repeat (3) begin
      tick();
      rd_seen |= bus.READ;
    end
    check("reset.read_never", rd_seen, 1'b0);
    check("reset.outputs", {bus.READ, bus.DATA_OUT, bus.Valid_out, bus.BUSY, bus.ERR}, 5'b0);
    check("reset.state", dbg_state, ST_IDLE);
    RESET = 1'b0;
    repeat (3) tick();
    check("idle_empty.outputs", {bus.READ, bus.Valid_out, bus.BUSY, dbg_state}, 6'b0);

    // AA with Valid in WAIT, then BB/A6 streamed, A8 with Valid on timeout edge
    for (int v = 0; v < 4; v++) begin
      run_frame($sformatf("frame%0d", v), vec_d[v], vec_dly[v], vec_exp[v], vec_par[v]);
    end
    check("frames.err", bus.ERR, 1'b0);
    bus.EMPTY = 1'b1;
    tick();
    check("drained.idle", {bus.READ, bus.BUSY, dbg_state}, 5'b0);

    // timeout: Valid held low
    bus.EMPTY = 1'b0;
    bus.Valid = 1'b0;
    tick();
    check("to.read", bus.READ, 1'b1);
    tick();
    vo_seen = bus.Valid_out;
    for (int i = 0; i < 3; i++) begin
      tick();
      vo_seen |= bus.Valid_out;
      check("to.waiting", {bus.ERR, dbg_state}, {1'b0, ST_WAIT});
    end
    tick();
    vo_seen |= bus.Valid_out;
    check("to.expired", {bus.ERR, bus.BUSY, dbg_state}, {2'b10, ST_IDLE});
    check("to.no_bits", vo_seen, 1'b0);
    tick();
    check("to.next_read", {bus.READ, bus.ERR}, 2'b11);
    bus.EMPTY = 1'b1;
    repeat (5) tick();
    check("to.sticky", {bus.ERR, dbg_state}, {1'b1, ST_IDLE});

    // reset during 4th bit of CC
    bus.EMPTY   = 1'b0;
    bus.DATA_IN = 8'hCC;
    tick();
    bus.Valid = 1'b1;
    tick();
    bus.Valid = 1'b0;
    repeat (3) tick();
    check("rst_mid.bit4", {bus.Valid_out, bus.DATA_OUT}, 2'b10);
    RESET = 1'b1;
    tick();
    check("rst_mid.cleared", {bus.Valid_out, bus.DATA_OUT, bus.READ, bus.BUSY, bus.ERR, dbg_state}, 8'b0);
    RESET     = 1'b0;
    bus.EMPTY = 1'b1;
    tick();
    check("rst_mid.no_resume", {bus.Valid_out, bus.READ, dbg_state}, 5'b0);
    run_frame("frame_dd", 8'hDD, 1, 8'b1101_1101, 1'b0);
    bus.EMPTY = 1'b1;

    // LSB-first instance
    for (int v = 0; v < 2; v++) begin
      got    = '0;
      vo_cnt = 0;
      bus2.EMPTY   = 1'b0;
      bus2.DATA_IN = lsb_d[v];
      bus2.Valid   = 1'b0;
      tick();
      check($sformatf("lsb%0d.read", v), bus2.READ, 1'b1);
      bus2.EMPTY = 1'b1;
      bus2.Valid = (lsb_dly[v] == 0);
      for (int i = 0; i < lsb_dly[v]; i++) begin
        tick();
        bus2.Valid = (i == lsb_dly[v] - 1);
      end
      tick();
      bus2.Valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        got[7-k] = bus2.DATA_OUT;
        if (bus2.Valid_out) vo_cnt++;
        if (k < 7) tick();
      end
      check($sformatf("lsb%0d.bits", v), got, lsb_exp[v]);
      check($sformatf("lsb%0d.vo_cnt", v), vo_cnt, 8);
      tick();
`ifdef SERIALIZER_PARITY_EN
      check($sformatf("lsb%0d.parity", v), {bus2.Valid_out, bus2.DATA_OUT}, {1'b1, lsb_par[v]});
      tick();
`endif
      check($sformatf("lsb%0d.end", v), {bus2.Valid_out, bus2.DATA_OUT, dbg_state_lsb}, {2'b00, ST_IDLE});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 The module SHALL have parameter WAIT_MAX, default 4, max cycles in WAIT for Valid before timeout (range 1-15).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1; 1 = bit 7 shifted first, 0 = bit 0 first.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 DATA_IN  input  8  byte from upstream buffer; sampled only when Valid=1 in REQ or WAIT.
REQ-006 Valid  input  1  upstream data-valid strobe returned in response to READ.
REQ-007 EMPTY  input  1  upstream buffer empty flag.
REQ-008 READ  output  1  registered one-cycle pop request to upstream buffer.
REQ-009 DATA_OUT  output  1  registered serial data bit.
REQ-010 Valid_out  output  1  high for every cycle DATA_OUT carries a data or parity bit.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 ERR  output  1  sticky timeout flag; cleared only by RESET.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, SHIFT and, when compiled in, PARITY; all outputs registered.
REQ-014 IDLE: at a rising edge with EMPTY=0, next state REQ and READ=1 for exactly that one cycle; with EMPTY=1, remain IDLE.
REQ-015 REQ: READ returns to 0 at next edge; if Valid=1 at that edge, load DATA_IN and go SHIFT, else go WAIT.
REQ-016 WAIT: wait counter SHALL count edges; Valid=1 loads DATA_IN and goes SHIFT; after WAIT_MAX edges without Valid, go IDLE, set ERR=1, no bits emitted.
REQ-017 Load edge SHALL also drive first bit: DATA_OUT=DATA_IN[7] (MSB_FIRST=1) or DATA_IN[0], Valid_out=1.
REQ-018 SHIFT SHALL emit exactly 8 bits on 8 consecutive cycles, 3-bit counter, no gaps.
REQ-019 After 8th bit: go PARITY if compiled in, else IDLE with Valid_out=0 and DATA_OUT=0.
REQ-020 Valid and DATA_IN SHALL be ignored in IDLE, SHIFT and PARITY; EMPTY SHALL be ignored outside IDLE.
REQ-021 Minimum spacing: first bit of next byte no earlier than 2 cycles after last bit (or parity) of the previous one (IDLE->REQ->load).
REQ-022 Valid and timeout on the same edge in WAIT: Valid SHALL win, byte loaded, ERR unchanged.
REQ-023 DATA_OUT SHALL be 0 whenever Valid_out=0.

Reset
REQ-024 RESET=1 at an edge SHALL force IDLE, READ=0, DATA_OUT=0, Valid_out=0, BUSY=0, ERR=0, counters and shift register 0, overriding all other inputs.
REQ-025 RESET mid-byte SHALL abort; remaining bits discarded, not resumed after release.
REQ-026 First READ after RESET deasserts SHALL occur no earlier than one edge after release with EMPTY=0.

Configuration
REQ-027 Macro SERIALIZER_PARITY_EN defined: PARITY state after 8th bit, one cycle with Valid_out=1, DATA_OUT=even parity (XOR of 8 data bits), then IDLE.
REQ-028 Macro SERIALIZER_PARITY_EN undefined: PARITY state and logic absent; frame is exactly 8 Valid_out cycles.

Verification
REQ-029 RESET 1 for 3 edges, EMPTY=1 -> all outputs 0, BUSY=0, READ never asserted.
REQ-030 EMPTY=0, Valid returned in WAIT with DATA_IN=8'hAA -> READ one cycle, then DATA_OUT 1,0,1,0,1,0,1,0 with Valid_out high 8 cycles; with parity, 9th bit 0.
REQ-031 Bytes 8'hBB, 8'hA6, 8'hA8 streamed with EMPTY=0, parity enabled -> serial 10111011+0, 10100110+0, 10101000+1, two idle cycles between frames.
REQ-032 EMPTY=0, Valid held 0, WAIT_MAX=4 -> IDLE after 4 WAIT cycles, ERR=1, Valid_out never high; next READ issued, ERR stays 1.
REQ-033 RESET asserted on 4th bit of 8'hCC -> next cycle Valid_out=0, DATA_OUT=0, ERR=0; new byte 8'hDD then serializes in full.
REQ-034 MSB_FIRST=0, DATA_IN=8'h01 loaded in REQ -> first bit 1 on load edge, then seven 0s.
